// File: rtl/adc_capture_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_seq_if
//  Brief    : Host command, ADC sample and upload-FIFO signal bundle for the
//             multi-channel ADC capture sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface adc_capture_seq_if #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 12
);
   logic                     restart_req;
   logic [NUM_CH-1:0]        channel_sel;
   logic [31:0]              data_num;
   logic [31:0]              speed_set;
   logic [NUM_CH*DATA_W-1:0] adc_data;
   logic                     fifo_full;
   logic                     fifo_wr_en;
   logic [4+DATA_W-1:0]      fifo_wr_data;
   logic                     busy;
   logic                     done;
   logic                     overrun;

   // Host / environment side: issues commands, supplies samples, owns the FIFO
   modport master (
      output restart_req, channel_sel, data_num, speed_set, adc_data, fifo_full,
      input  fifo_wr_en, fifo_wr_data, busy, done, overrun
   );

   // Capture sequencer side
   modport slave (
      input  restart_req, channel_sel, data_num, speed_set, adc_data, fifo_full,
      output fifo_wr_en, fifo_wr_data, busy, done, overrun
   );
endinterface
`default_nettype wire

// File: rtl/adc_capture_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_seq
//  Brief    : Multi-channel ADC capture sequencer. Divides clk into a sample
//             tick, snapshots all channels on each tick and serialises the
//             enabled ones, tagged with their channel index, into the upload
//             FIFO. Reports busy, a done pulse and a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module adc_capture_seq #(
   parameter int NUM_CH = 8,   // must match the interface instance, <= 16
   parameter int DATA_W = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   adc_capture_seq_if.slave bus
);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_SCAN = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]               state_q,   state_d;
   logic [NUM_CH-1:0]        sel_q,     sel_d;
   logic [31:0]              num_q,     num_d;
   logic [31:0]              period_q,  period_d;
   logic [31:0]              div_q,     div_d;
   logic [31:0]              frame_q,   frame_d;
   logic [NUM_CH*DATA_W-1:0] snap_q,    snap_d;
   logic [PTR_W-1:0]         ptr_q,     ptr_d;
   logic                     overrun_q, overrun_d;

   logic                     w_run;
   logic                     w_tick;
   logic                     w_wr_en;
   logic                     w_last;
   logic [PTR_W-1:0]         w_first_ptr;
   logic [PTR_W-1:0]         w_next_ptr;
   logic [31:0]              w_frame_inc;

   // Divider only runs while waiting for or scanning a frame
   assign w_run       = (state_q == S_WAIT) || (state_q == S_SCAN);
   assign w_tick      = w_run && (div_q == period_q - 32'd1);
   // A restart in the same cycle aborts the scan before this write happens
   assign w_wr_en     = (state_q == S_SCAN) && !bus.fifo_full && !bus.restart_req;
   assign w_frame_inc = frame_q + 32'd1;

   // Lowest enabled channel, and next enabled channel above the current pointer
   always_comb begin
      w_first_ptr = '0;
      w_next_ptr  = '0;
      w_last      = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (sel_q[i]) begin
            w_first_ptr = PTR_W'(i);
         end
         if (sel_q[i] && (i > int'(ptr_q))) begin
            w_next_ptr = PTR_W'(i);
            w_last     = 1'b0;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; restart overrides every state
   always_comb begin
      state_d = state_q;
      if (bus.restart_req) begin
         state_d = S_ARM;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ARM: begin
               if ((sel_q == '0) || (num_q == 32'd0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_tick) begin
                  state_d = S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_wr_en && w_last) begin
                  state_d = (w_frame_inc == num_q) ? S_DONE : S_WAIT;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic, decoded from state and the datapath registers
   always_comb begin
      bus.fifo_wr_en   = w_wr_en;
      bus.fifo_wr_data = {4'(ptr_q), snap_q[int'(ptr_q) * DATA_W +: DATA_W]};
      bus.busy         = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_SCAN);
      bus.done         = (state_q == S_DONE);
      bus.overrun      = overrun_q;
   end

   // Datapath next values: config latch, divider, snapshot, pointer, counters
   always_comb begin
      sel_d     = sel_q;
      num_d     = num_q;
      period_d  = period_q;
      div_d     = div_q;
      frame_d   = frame_q;
      snap_d    = snap_q;
      ptr_d     = ptr_q;
      overrun_d = overrun_q;
      if (bus.restart_req) begin
         sel_d     = bus.channel_sel;
         num_d     = bus.data_num;
         period_d  = (bus.speed_set == 32'd0) ? 32'd1 : bus.speed_set;
         div_d     = '0;
         frame_d   = '0;
         overrun_d = 1'b0;
      end else begin
         if (w_run) begin
            div_d = w_tick ? 32'd0 : div_q + 32'd1;
         end else begin
            div_d = '0;
         end
         if ((state_q == S_WAIT) && w_tick) begin
            snap_d = bus.adc_data;
            ptr_d  = w_first_ptr;
         end
         if (state_q == S_SCAN) begin
            // A tick while still draining is dropped and flagged
            if (w_tick) begin
               overrun_d = 1'b1;
            end
            if (w_wr_en) begin
               if (w_last) begin
                  frame_d = w_frame_inc;
               end else begin
                  ptr_d = w_next_ptr;
               end
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q     <= '0;
         num_q     <= '0;
         period_q  <= '0;
         div_q     <= '0;
         frame_q   <= '0;
         snap_q    <= '0;
         ptr_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         num_q     <= num_d;
         period_q  <= period_d;
         div_q     <= div_d;
         frame_q   <= frame_d;
         snap_q    <= snap_d;
         ptr_q     <= ptr_d;
         overrun_q <= overrun_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_adc_capture_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_seq
//  Brief    : Directed, table-driven bench for adc_capture_seq. Each ADC
//             sample encodes {clock edge index[7:0], channel[3:0]} so the
//             captured tick is visible in every FIFO word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_seq;
   localparam int NUM_CH = 8;
   localparam int DATA_W = 12;

   typedef struct {
      logic [7:0]  sel;
      logic [31:0] num;
      logic [31:0] speed;
      int          stall_off;   // frame-0 writes completed before fifo_full rises
      int          stall_len;   // cycles fifo_full stays high (0 = never)
      int          exp_writes;
      logic        exp_ovr;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   edge_n = 0;
   int   total = 0;
   int   bad = 0;

   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   int          exp_done_n;
   int          done_cnt = 0;
   int          done_n = 0;
   int          viol_cnt = 0;
   logic [NUM_CH*DATA_W-1:0] adc_w;

   adc_capture_seq_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) ifc ();

   adc_capture_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen at a posedge is that edge's index
   always @(posedge clk) edge_n <= edge_n + 1;

   // Sample pattern tracks the edge counter
   always_comb begin
      adc_w = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         adc_w[i*DATA_W +: DATA_W] = {edge_n[7:0], i[3:0]};
      end
   end
   assign ifc.adc_data = adc_w;

   // Output monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (ifc.fifo_wr_en) begin
         got_q.push_back(ifc.fifo_wr_data);
         if (ifc.fifo_full || !ifc.busy) viol_cnt = viol_cnt + 1;
      end
      if (ifc.done) begin
         done_cnt = done_cnt + 1;
         done_n   = edge_n;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   // Expected FIFO stream and done timing, derived from the capture rules
   task automatic build_exp(input vec_t v, input int r);
      int p, c, l, n_en;
      exp_q.delete();
      p    = (v.speed == 0) ? 1 : int'(v.speed);
      n_en = $countones(v.sel);
      exp_done_n = r + 2;
      if (v.sel != 0 && v.num != 0) begin
         c = r + 1 + p;
         for (int k = 0; k < int'(v.num); k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               if (v.sel[ch]) exp_q.push_back({ch[3:0], c[7:0], ch[3:0]});
            end
            l = n_en + ((k == 0) ? v.stall_len : 0);
            if (k == int'(v.num) - 1) exp_done_n = c + l + 1;
            else c = c + p * (l / p + 1);
         end
      end
   endtask

   // Pulse restart with a new configuration; r = edge index that samples it
   task automatic start_cfg(input vec_t v, output int r);
      ifc.channel_sel = v.sel;
      ifc.data_num    = v.num;
      ifc.speed_set   = v.speed;
      ifc.restart_req = 1'b1;
      r = edge_n;
      tick_clk();
      ifc.restart_req = 1'b0;
   endtask

   // Run to completion from restart edge r and compare everything observed
   task automatic finish_run(input string tag, input vec_t v, input int r,
                             input int got_base, input int done_base, input int viol_base);
      int p, c0, k;
      p  = (v.speed == 0) ? 1 : int'(v.speed);
      c0 = r + 1 + p;
      build_exp(v, r);
      k = 0;
      while (done_cnt == done_base && k < 800) begin
         if (v.stall_len > 0 && edge_n == c0 + v.stall_off + 1) ifc.fifo_full = 1'b1;
         if (v.stall_len > 0 && edge_n == c0 + v.stall_off + 1 + v.stall_len) ifc.fifo_full = 1'b0;
         tick_clk();
         k++;
      end
      ifc.fifo_full = 1'b0;
      check({tag, " done_reached"}, 32'(done_cnt > done_base), 32'd1);
      repeat (4) tick_clk();
      check({tag, " write_count"}, 32'(got_q.size() - got_base), 32'(v.exp_writes));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (got_base + i < got_q.size())
            check({tag, " write_data"}, 32'(got_q[got_base + i]), 32'(exp_q[i]));
         else
            check({tag, " write_missing"}, 32'hFFFF_FFFF, 32'(exp_q[i]));
      end
      check({tag, " done_pulses"}, 32'(done_cnt - done_base), 32'd1);
      check({tag, " done_time"}, 32'(done_n), 32'(exp_done_n));
      check({tag, " overrun"}, 32'(ifc.overrun), 32'(v.exp_ovr));
      check({tag, " busy_end"}, 32'(ifc.busy), 32'd0);
      check({tag, " wr_while_full"}, 32'(viol_cnt - viol_base), 32'd0);
   endtask

   initial begin
      vec_t vecs[8];
      vec_t v;
      int   r, c0, gb, db, vb;

      vecs[0] = '{8'h05, 32'd3, 32'd4, 0, 0,  6, 1'b0};
      vecs[1] = '{8'h01, 32'd2, 32'd0, 0, 0,  2, 1'b1};
      vecs[2] = '{8'hFF, 32'd2, 32'd4, 3, 10, 16, 1'b1};
      vecs[3] = '{8'h00, 32'd3, 32'd4, 0, 0,  0, 1'b0};
      vecs[4] = '{8'h0F, 32'd0, 32'd4, 0, 0,  0, 1'b0};
      vecs[5] = '{8'h81, 32'd2, 32'd5, 0, 0,  4, 1'b0};
      vecs[6] = '{8'h18, 32'd1, 32'd2, 0, 0,  2, 1'b1};
      vecs[7] = '{8'h80, 32'd1, 32'd1, 0, 0,  1, 1'b1};

      ifc.restart_req = 1'b0;
      ifc.channel_sel = '0;
      ifc.data_num    = '0;
      ifc.speed_set   = '0;
      ifc.fifo_full   = 1'b0;
      repeat (3) tick_clk();
      check("reset wr_en",   32'(ifc.fifo_wr_en),   32'd0);
      check("reset wr_data", 32'(ifc.fifo_wr_data), 32'd0);
      check("reset busy",    32'(ifc.busy),         32'd0);
      check("reset done",    32'(ifc.done),         32'd0);
      check("reset overrun", 32'(ifc.overrun),      32'd0);
      reset_n = 1'b1;
      repeat (2) tick_clk();

      for (int i = 0; i < 8; i++) begin
         gb = got_q.size(); db = done_cnt; vb = viol_cnt;
         start_cfg(vecs[i], r);
         finish_run($sformatf("vec%0d", i), vecs[i], r, gb, db, vb);
      end

      // Restart mid-scan: abort an overrunning 8-channel capture, switch to ch7
      v = '{8'hFF, 32'd10, 32'd2, 0, 0, 0, 1'b1};
      gb = got_q.size();
      start_cfg(v, r);
      c0 = r + 3;
      while (edge_n < c0 + 3) tick_clk();
      check("abort pre_writes", 32'(got_q.size() - gb), 32'd2);
      if (got_q.size() >= gb + 2) begin
         check("abort pre_ch0", 32'(got_q[gb]),     32'({4'd0, c0[7:0], 4'd0}));
         check("abort pre_ch1", 32'(got_q[gb + 1]), 32'({4'd1, c0[7:0], 4'd1}));
      end
      check("abort pre_overrun", 32'(ifc.overrun), 32'd1);
      v = '{8'h80, 32'd2, 32'd3, 0, 0, 2, 1'b0};
      gb = got_q.size(); db = done_cnt; vb = viol_cnt;
      start_cfg(v, r);
      finish_run("abort", v, r, gb, db, vb);

      // Asynchronous reset mid-scan, then silence until the next restart
      v = '{8'hFF, 32'd4, 32'd1, 0, 0, 0, 1'b1};
      gb = got_q.size(); db = done_cnt;
      start_cfg(v, r);
      c0 = r + 2;
      while (edge_n < c0 + 2) tick_clk();
      check("rst pre_overrun", 32'(ifc.overrun), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst wr_en",   32'(ifc.fifo_wr_en),   32'd0);
      check("rst wr_data", 32'(ifc.fifo_wr_data), 32'd0);
      check("rst busy",    32'(ifc.busy),         32'd0);
      check("rst done",    32'(ifc.done),         32'd0);
      check("rst overrun", 32'(ifc.overrun),      32'd0);
      repeat (2) tick_clk();
      reset_n = 1'b1;
      repeat (30) tick_clk();
      check("rst writes", 32'(got_q.size() - gb), 32'd1);
      check("rst no_done", 32'(done_cnt - db), 32'd0);
      check("rst busy_after", 32'(ifc.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
